gun_flash_seq: RTL and testbench

Display-side counterpart of the light-gun input path. On a gun trigger pull, it sequences one all-black frame, then TARGET_FRAMES frames with a white box drawn over the duck. It samples the photodetector across those frames and emits one-cycle shot_fired, hit and miss pulses. It sits between the gun connector and the draw pipeline; blank_screen and draw_target_box feed the draw pipeline's overlay selectors.

---
 rtl/gun_pkg.sv | 17 +
 rtl/gun_sync.sv | 29 ++
 rtl/gun_flash_seq.sv | 173 +++++++++++++++++
 tb/tb_gun_flash_seq.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/gun_pkg.sv
// Shared types and widths for the light-gun flash sequencer.
// Imported by gun_flash_seq; optional macro: GUN_FLASH_BLANK_CHECK_EN.
package gun_pkg;

  localparam int DET_CNT_W   = 8;
  localparam int FRAME_CNT_W = 4;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARM     = 3'd1,
    S_BLANK   = 3'd2,
    S_TARGET  = 3'd3,
    S_RESULT  = 3'd4,
    S_HOLDOFF = 3'd5
  } gun_flash_state_t;

endpackage

// File: rtl/gun_sync.sv
// Multi-flop synchronizer for a raw gun input with a
// one-cycle pulse on the synchronized 1->0 transition.
module gun_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              q_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
      q_d   <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      q_d   <= chain[STAGES-1];
    end
  end

  assign q    = chain[STAGES-1];
  assign fall = q_d & ~q;

endmodule

// File: rtl/gun_flash_seq.sv
// Light-gun flash sequencer: black frame, target-box frames, hit/miss.
// Optional GUN_FLASH_BLANK_CHECK_EN: light seen during BLANK forces miss.
module gun_flash_seq
  import gun_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TARGET_FRAMES  = 1,
  parameter int DET_MIN_CYCLES = 16,
  parameter int HOLDOFF_FRAMES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic gun_is_connected,
  input  logic gun_trigger,
  input  logic gun_photodetector,
  input  logic frame_start,
  output logic blank_screen,
  output logic draw_target_box,
  output logic shot_fired,
  output logic hit,
  output logic miss,
  output logic busy
);

  localparam logic [DET_CNT_W-1:0] DET_MIN =
    DET_CNT_W'(DET_MIN_CYCLES);
  localparam logic [FRAME_CNT_W-1:0] TGT_LD =
    FRAME_CNT_W'(TARGET_FRAMES);
  localparam logic [FRAME_CNT_W-1:0] HOLD_LD =
    FRAME_CNT_W'(HOLDOFF_FRAMES);

  gun_flash_state_t        state;
  logic [DET_CNT_W-1:0]    det_cnt;
  logic [DET_CNT_W-1:0]    det_next;
  logic [FRAME_CNT_W-1:0]  frame_cnt;
  logic [FRAME_CNT_W-1:0]  hold_cnt;
  logic                    light_seen;
  logic                    result_hit;
  logic                    trig_q;
  logic                    trig_fall;
  logic                    photo_q;
  logic                    photo_fall_unused;
`ifdef GUN_FLASH_BLANK_CHECK_EN
  logic                    cheat;
`endif

  gun_sync #(.STAGES(SYNC_STAGES)) u_trig_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (gun_trigger),
    .q     (trig_q),
    .fall  (trig_fall)
  );

  gun_sync #(.STAGES(SYNC_STAGES)) u_photo_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (gun_photodetector),
    .q     (photo_q),
    .fall  (photo_fall_unused)
  );

  // saturating run-length of consecutive lit cycles
  assign det_next = (det_cnt == DET_MIN) ? det_cnt
                                         : det_cnt + 1'b1;

`ifdef GUN_FLASH_BLANK_CHECK_EN
  assign result_hit = light_seen & ~cheat;
`else
  assign result_hit = light_seen;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      det_cnt    <= '0;
      frame_cnt  <= '0;
      hold_cnt   <= '0;
      light_seen <= 1'b0;
      shot_fired <= 1'b0;
      hit        <= 1'b0;
      miss       <= 1'b0;
`ifdef GUN_FLASH_BLANK_CHECK_EN
      cheat      <= 1'b0;
`endif
    end else begin
      shot_fired <= 1'b0;
      hit        <= 1'b0;
      miss       <= 1'b0;
      if (!gun_is_connected) begin
        state      <= S_IDLE;
        det_cnt    <= '0;
        frame_cnt  <= '0;
        hold_cnt   <= '0;
        light_seen <= 1'b0;
`ifdef GUN_FLASH_BLANK_CHECK_EN
        cheat      <= 1'b0;
`endif
      end else begin
        unique case (state)
          S_IDLE: begin
            if (trig_fall) begin
              state      <= S_ARM;
              shot_fired <= 1'b1;
            end
          end
          S_ARM: begin
            if (frame_start) begin
              state      <= S_BLANK;
              det_cnt    <= '0;
              light_seen <= 1'b0;
`ifdef GUN_FLASH_BLANK_CHECK_EN
              cheat      <= 1'b0;
`endif
            end
          end
          S_BLANK: begin
`ifdef GUN_FLASH_BLANK_CHECK_EN
            if (photo_q) begin
              det_cnt <= det_next;
              if (det_next == DET_MIN)
                cheat <= 1'b1;
            end else begin
              det_cnt <= '0;
            end
`endif
            if (frame_start) begin
              state     <= S_TARGET;
              frame_cnt <= TGT_LD;
              det_cnt   <= '0;
            end
          end
          S_TARGET: begin
            if (photo_q) begin
              det_cnt <= det_next;
              if (det_next == DET_MIN)
                light_seen <= 1'b1;
            end else begin
              det_cnt <= '0;
            end
            if (frame_start) begin
              if (frame_cnt <= 1)
                state <= S_RESULT;
              else
                frame_cnt <= frame_cnt - 1'b1;
            end
          end
          S_RESULT: begin
            hit       <= result_hit;
            miss      <= ~result_hit;
            state     <= S_HOLDOFF;
            hold_cnt  <= HOLD_LD;
            det_cnt   <= '0;
            frame_cnt <= '0;
          end
          S_HOLDOFF: begin
            // re-arm only once the trigger has been let go
            if (hold_cnt == '0 && trig_q)
              state <= S_IDLE;
            else if (frame_start && hold_cnt != '0)
              hold_cnt <= hold_cnt - 1'b1;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign blank_screen    = (state == S_BLANK);
  assign draw_target_box = (state == S_TARGET);
  assign busy            = (state != S_IDLE);

endmodule

// File: tb/tb_gun_flash_seq.sv
// Directed bench for gun_flash_seq with default parameters.
// Expected hit/miss for the lamp test follows GUN_FLASH_BLANK_CHECK_EN.
module tb_gun_flash_seq;

  localparam int L = 160;
`ifdef GUN_FLASH_BLANK_CHECK_EN
  localparam int LAMP_HIT = 0;
`else
  localparam int LAMP_HIT = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic conn = 1'b1;
  logic trig = 1'b1;
  logic photo = 1'b0;
  logic fs = 1'b0;
  logic blank_screen, draw_target_box;
  logic shot_fired, hit, miss, busy;

  int n_chk = 0;
  int n_pass = 0;
  int shots = 0, blanks = 0, targets = 0;
  int hits = 0, misses = 0, both = 0;
  int s_sh, s_bl, s_tg, s_hi, s_mi;

  gun_flash_seq dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .gun_is_connected  (conn),
    .gun_trigger       (trig),
    .gun_photodetector (photo),
    .frame_start       (fs),
    .blank_screen      (blank_screen),
    .draw_target_box   (draw_target_box),
    .shot_fired        (shot_fired),
    .hit               (hit),
    .miss              (miss),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (shot_fired) shots++;
    if (blank_screen) blanks++;
    if (draw_target_box) targets++;
    if (hit) hits++;
    if (miss) misses++;
    if (hit && miss) both++;
  end

  task automatic check(input string tag, input int got,
                       input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d",
                  tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    s_sh = shots; s_bl = blanks; s_tg = targets;
    s_hi = hits;  s_mi = misses;
  endtask

  function automatic logic photo_of(input int mode,
                                    input int i);
    case (mode)
      1: return (i >= 30 && i < 130);
      2: return ((i % 20) < 10);
      3: return ((i % 20) < 16);
      4: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic run_frame(input int mode);
    for (int i = 0; i < L; i++) begin
      fs = (i == 0);
      photo = photo_of(mode, i);
      step();
    end
    fs = 1'b0;
  endtask

  task automatic shot(input string tag, input int mb,
                      input int mt, input int exp_hit);
    snap();
    trig = 1'b0;
    repeat (4) step();
    run_frame(mb);
    run_frame(mt);
    fs = 1'b1; photo = 1'b0;
    step();
    fs = 1'b0;
    step();
    check({tag, ".hit"}, hit, exp_hit);
    check({tag, ".miss"}, miss, 1 - exp_hit);
    trig = 1'b1;
    repeat (L - 2) step();
    check({tag, ".shots"}, shots - s_sh, 1);
    check({tag, ".blank"}, blanks - s_bl, L);
    check({tag, ".target"}, targets - s_tg, L);
    check({tag, ".nhit"}, hits - s_hi, exp_hit);
    check({tag, ".nmiss"}, misses - s_mi, 1 - exp_hit);
    repeat (3) run_frame(0);
    check({tag, ".hold_busy"}, busy, 1);
    run_frame(0);
    check({tag, ".rearm"}, busy, 0);
  endtask

  initial begin
    repeat (3) step();
    check("rst.busy", busy, 0);
    check("rst.blank", blank_screen, 0);
    check("rst.box", draw_target_box, 0);
    check("rst.shot", shot_fired, 0);
    check("rst.hit", hit, 0);
    check("rst.miss", miss, 0);
    rst_n = 1'b1;
    repeat (5) step();

    shot("lit100", 0, 1, 1);
    shot("dark", 0, 0, 0);
    shot("burst10", 0, 2, 0);
    shot("burst16", 0, 3, 1);
    shot("lamp", 4, 4, LAMP_HIT);

    // second pull in TARGET, trigger held through holdoff
    snap();
    trig = 1'b0;
    repeat (4) step();
    trig = 1'b1;
    repeat (4) step();
    run_frame(0);
    fs = 1'b1; step(); fs = 1'b0;
    repeat (20) step();
    trig = 1'b0;
    repeat (L - 21) step();
    fs = 1'b1; step(); fs = 1'b0; step();
    check("repull.miss", miss, 1);
    repeat (L - 2) step();
    repeat (4) run_frame(0);
    check("repull.busy4", busy, 1);
    repeat (10) step();
    check("repull.busy_held", busy, 1);
    trig = 1'b1;
    repeat (4) step();
    check("repull.release", busy, 0);
    check("repull.shots", shots - s_sh, 1);

    // disconnect during BLANK
    snap();
    trig = 1'b0;
    repeat (4) step();
    fs = 1'b1; step(); fs = 1'b0;
    repeat (10) step();
    check("disc.blank_on", blank_screen, 1);
    conn = 1'b0;
    step();
    check("disc.blank", blank_screen, 0);
    check("disc.busy", busy, 0);
    check("disc.box", draw_target_box, 0);
    trig = 1'b1;
    repeat (3) step();
    conn = 1'b1;
    repeat (3) run_frame(0);
    check("disc.result", (hits - s_hi) + (misses - s_mi), 0);
    check("disc.idle", busy, 0);

    // async reset during TARGET
    snap();
    trig = 1'b0;
    repeat (4) step();
    run_frame(0);
    fs = 1'b1; step(); fs = 1'b0;
    photo = 1'b1;
    repeat (10) step();
    check("arst.box_on", draw_target_box, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst.box", draw_target_box, 0);
    check("arst.busy", busy, 0);
    check("arst.blank", blank_screen, 0);
    trig = 1'b1; photo = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (3) run_frame(0);
    check("arst.result", (hits - s_hi) + (misses - s_mi), 0);
    check("arst.idle", busy, 0);

    check("never_both", both, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
